// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback queue feeding the register file and hi/lo
// Define WB_BYPASS_EN to forward pending queue entries to the read ports and hi/lo outputs.
module alu_writeback #(
  parameter int DEPTH = 2,
  parameter int NREG  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr_ID,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        wb_stall,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef struct packed {
    logic        wr_rd;
    logic        wr_hl;
    logic [4:0]  addr;
    logic [31:0] rd;
    logic [31:0] hi;
    logic [31:0] lo;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   regs_q [NREG];
  logic [31:0]   regs_d [NREG];
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic   accept;
  logic   commit;
  logic   dec_wr_rd;
  logic   dec_wr_hl;
  entry_t new_ent;
  entry_t head;

  assign in_ready = (count_q != CW'(DEPTH));
  assign busy     = (count_q != '0);
  assign accept   = in_valid && in_ready;
  assign commit   = busy && !wb_stall;

  always_comb begin
    dec_wr_rd = 1'b0;
    dec_wr_hl = 1'b0;
    if ((instr_ID >= 32'd1 && instr_ID <= 32'd12) || instr_ID == 32'd24 || instr_ID == 32'd25) begin
      dec_wr_rd = 1'b1;
    end else if (instr_ID == 32'd26 || instr_ID == 32'd27) begin
      dec_wr_hl = 1'b1;
    end else if (instr_ID == 32'd28) begin
      dec_wr_rd = 1'b1;
      dec_wr_hl = 1'b1;
    end
  end

  // Class 28 writes lo_in to rd, so the rd value is resolved at accept time.
  always_comb begin
    new_ent       = '0;
    new_ent.wr_rd = dec_wr_rd;
    new_ent.wr_hl = dec_wr_hl;
    new_ent.addr  = rd_addr;
    new_ent.rd    = (instr_ID == 32'd28) ? lo_in : rd_data;
    new_ent.hi    = hi_in;
    new_ent.lo    = lo_in;
  end

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    regs_d   = regs_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    head     = ent_q[rd_ptr_q];
    if (accept) begin
      ent_d[wr_ptr_q] = new_ent;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (commit) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (head.wr_rd && int'(head.addr) < NREG) begin
        regs_d[head.addr[AW-1:0]] = head.rd;
      end
      if (head.wr_hl) begin
        hi_d = head.hi;
        lo_d = head.lo;
      end
    end
    count_d = count_q + CW'(accept) - CW'(commit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      regs_q   <= regs_d;
      ent_q    <= ent_d;
    end
  end

  always_comb begin
    rs_data = (int'(rs_addr) < NREG) ? regs_q[rs_addr[AW-1:0]] : 32'd0;
    rt_data = (int'(rt_addr) < NREG) ? regs_q[rt_addr[AW-1:0]] : 32'd0;
    hi      = hi_q;
    lo      = lo_q;
`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (ent_q[rd_ptr_q + PW'(i)].wr_rd && ent_q[rd_ptr_q + PW'(i)].addr == rs_addr) begin
          rs_data = ent_q[rd_ptr_q + PW'(i)].rd;
        end
        if (ent_q[rd_ptr_q + PW'(i)].wr_rd && ent_q[rd_ptr_q + PW'(i)].addr == rt_addr) begin
          rt_data = ent_q[rd_ptr_q + PW'(i)].rd;
        end
        if (ent_q[rd_ptr_q + PW'(i)].wr_hl) begin
          hi = ent_q[rd_ptr_q + PW'(i)].hi;
          lo = ent_q[rd_ptr_q + PW'(i)].lo;
        end
      end
    end
`endif
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameters SHALL be: DEPTH, 2, writeback queue entries (power of two, 2..8); NREG, 32, architectural registers.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  ALU result valid this cycle.
REQ-005 in_ready  output  1  queue can accept; high iff queue not full.
REQ-006 instr_ID  input  32  decoded instruction ID of the result.
REQ-007 rd_addr  input  5  destination register address.
REQ-008 rd_data  input  32  ALU rd result.
REQ-009 hi_in  input  32  ALU hi result.
REQ-010 lo_in  input  32  ALU lo result.
REQ-011 wb_stall  input  1  high blocks commit this cycle.
REQ-012 rs_addr, rt_addr  input  5 each  read port addresses.
REQ-013 rs_data, rt_data  output  32 each  combinational read data.
REQ-014 hi, lo  output  32 each  architectural hi/lo registers.
REQ-015 busy  output  1  high iff queue non-empty.

Function
REQ-016 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; the entry captures instr_ID class, rd_addr, rd_data, hi_in, lo_in.
REQ-017 Class decode SHALL be: IDs 1-12, 24, 25 -> write rd only; 26, 27 -> write hi and lo only; 28 -> write rd=lo_in, hi, lo; 0 and all others -> accepted, no register write.
REQ-018 Commit SHALL retire the oldest entry on a rising edge when busy=1 and wb_stall=0, at most one entry per cycle, in strict acceptance order.
REQ-019 Minimum latency SHALL be one cycle: accepted at edge N, visible in register file/hi/lo after edge N+1 when wb_stall=0.
REQ-020 Simultaneous accept and commit SHALL be permitted, including when full (in_ready reflects pre-edge occupancy; full queue stays not-ready that cycle).
REQ-021 in_valid while in_ready=0 SHALL be ignored; source holds values until accepted.
REQ-022 Queue pointers SHALL wrap modulo DEPTH; occupancy counter SHALL range 0..DEPTH with no overflow/underflow.
REQ-023 Register r0 SHALL be ordinary and writable; all NREG registers 32-bit.
REQ-024 rs_data/rt_data SHALL be combinational from the register file for the presented address.
REQ-025 wb_stall=1 with empty queue SHALL have no effect; wb_stall does not affect in_ready except via occupancy.

Reset
REQ-026 On reset=1 at a rising edge: queue emptied, pointers and count 0, all registers, hi, lo SHALL be 0.
REQ-027 Reset SHALL override same-edge accept and commit; pending entries are discarded, not committed.
REQ-028 After reset: in_ready=1, busy=0, rs_data=rt_data=hi=lo=0.

Configuration
REQ-029 Macro WB_BYPASS_EN SHALL control read forwarding.
REQ-030 With WB_BYPASS_EN defined: rs_data/rt_data SHALL return the youngest pending rd-writing entry matching the address, else register file; hi/lo outputs SHALL return youngest pending hi/lo-writing entry values, else architectural.
REQ-031 Without WB_BYPASS_EN: reads and hi/lo SHALL reflect committed state only.

Verification
REQ-032 Reset then ID=1, rd_addr=5, rd_data=0x0000_000A, wb_stall=0 -> after 2 edges reading r5 gives 0x0000_000A, busy=0.
REQ-033 ID=28, rd_addr=3, hi_in=0x1, lo_in=0xFFFF_FFFE -> r3=0xFFFF_FFFE, hi=0x1, lo=0xFFFF_FFFE; ID=26 hi_in=2 lo_in=3 -> hi=2, lo=3, r3 unchanged.
REQ-034 wb_stall=1, push 2 entries (DEPTH=2) -> in_ready=0, third push ignored; release stall -> commits in order on 2 consecutive edges, in_ready returns 1 after first.
REQ-035 Two entries to r7 (0x11 then 0x22) queued under stall, read r7 -> 0x22 with WB_BYPASS_EN, prior value without; after drain r7=0x22 both builds.
REQ-036 Queue holding 2 entries, reset asserted one cycle -> all registers 0, busy=0, entries never committed.
REQ-037 ID=0 and ID=15 accepted -> busy pulses, no register/hi/lo change.
